// File: rtl/lock_code_fsm.sv
// Keypad code-entry controller: assembles a 4-digit BCD code, compares it to a
// secret, and sequences unlock/error/lockout windows timed by the divider's slow clock.
module lock_code_fsm #(
    parameter logic [15:0] CODE          = 16'h1234,
    parameter logic [7:0]  TIMEOUT_TICKS = 8'd10,
    parameter logic [7:0]  OPEN_TICKS    = 8'd15,
    parameter logic [7:0]  ERROR_TICKS   = 8'd3,
    parameter logic [2:0]  MAX_FAILS     = 3'd3,
    parameter logic [7:0]  LOCKOUT_TICKS = 8'd60
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       slow_clk,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic       unlocked,
    output logic       error,
    output logic       locked_out,
    output logic [2:0] digit_count,
    output logic [2:0] fail_count,
    output logic [2:0] state_o
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned CODE_W  = 16;
    localparam int unsigned TICK_W  = 8;
    localparam int unsigned CNT_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_ERROR   = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_t;

    state_t                r_state;
    logic [CODE_W-1:0]     r_entry;
    logic [TICK_W-1:0]     r_tick_cnt;
    logic [CNT_W-1:0]      r_digit_cnt;
    logic [CNT_W-1:0]      r_fail_cnt;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_sync3;

    logic                  w_tick;
    logic                  w_key_num;
    logic                  w_key_clr;
    logic [TICK_W-1:0]     w_tick_next;
    logic [CNT_W-1:0]      w_fail_next;

    // Rising-edge detect on the synchronised slow clock gives a one-cycle tick
    assign w_tick      = r_sync2 & ~r_sync3;
    assign w_key_num   = key_valid && (key_digit <= DIGIT_W'(9));
    assign w_key_clr   = key_valid && (key_digit == DIGIT_W'(4'hC));
    assign w_tick_next = r_tick_cnt + TICK_W'(1);
    assign w_fail_next = r_fail_cnt + CNT_W'(1);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_entry     <= '0;
            r_tick_cnt  <= '0;
            r_digit_cnt <= '0;
            r_fail_cnt  <= '0;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync3     <= 1'b0;
        end else begin
            r_sync1 <= slow_clk;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            case (r_state)
                ST_IDLE: begin
                    if (w_key_num) begin
                        r_entry     <= CODE_W'(key_digit);
                        r_digit_cnt <= CNT_W'(1);
                        r_tick_cnt  <= '0;
                        r_state     <= ST_ENTRY;
                    end
                end

                // A key in the same cycle as a tick takes priority and restarts the timeout
                ST_ENTRY: begin
                    if (w_key_num) begin
                        r_entry     <= {r_entry[CODE_W-DIGIT_W-1:0], key_digit};
                        r_digit_cnt <= r_digit_cnt + CNT_W'(1);
                        r_tick_cnt  <= '0;
                        if (r_digit_cnt == CNT_W'(3)) begin
                            r_state <= ST_CHECK;
                        end
                    end else if (w_key_clr) begin
                        r_digit_cnt <= '0;
                        r_tick_cnt  <= '0;
                        r_state     <= ST_IDLE;
                    end else if (w_tick) begin
                        if (w_tick_next == TIMEOUT_TICKS) begin
                            r_digit_cnt <= '0;
                            r_tick_cnt  <= '0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_tick_cnt <= w_tick_next;
                        end
                    end
                end

                ST_CHECK: begin
                    r_digit_cnt <= '0;
                    r_tick_cnt  <= '0;
                    if (r_entry == CODE) begin
                        r_fail_cnt <= '0;
                        r_state    <= ST_OPEN;
                    end else if (w_fail_next == MAX_FAILS) begin
                        r_fail_cnt <= MAX_FAILS;
                        r_state    <= ST_LOCKOUT;
                    end else begin
                        r_fail_cnt <= w_fail_next;
                        r_state    <= ST_ERROR;
                    end
                end

                ST_OPEN: begin
                    if (w_tick) begin
                        if (w_tick_next == OPEN_TICKS) begin
                            r_tick_cnt <= '0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_tick_cnt <= w_tick_next;
                        end
                    end
                end

                ST_ERROR: begin
                    if (w_tick) begin
                        if (w_tick_next == ERROR_TICKS) begin
                            r_tick_cnt <= '0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_tick_cnt <= w_tick_next;
                        end
                    end
                end

                ST_LOCKOUT: begin
                    if (w_tick) begin
                        if (w_tick_next == LOCKOUT_TICKS) begin
                            r_tick_cnt <= '0;
                            r_fail_cnt <= '0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_tick_cnt <= w_tick_next;
                        end
                    end
                end

                default: begin
                    r_tick_cnt  <= '0;
                    r_digit_cnt <= '0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Status flags decode straight from the state register
    assign unlocked    = (r_state == ST_OPEN);
    assign error       = (r_state == ST_ERROR);
    assign locked_out  = (r_state == ST_LOCKOUT);
    assign digit_count = r_digit_cnt;
    assign fail_count  = r_fail_cnt;
    assign state_o     = CNT_W'(r_state);

endmodule

// File: tb/tb_lock_code_fsm.sv
// Directed bench for lock_code_fsm: code entry, errors, lockout, timeout, clear and reset.
module tb_lock_code_fsm;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       slow_clk;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       unlocked;
    logic       error;
    logic       locked_out;
    logic [2:0] digit_count;
    logic [2:0] fail_count;
    logic [2:0] state_o;

    int checks   = 0;
    int failures = 0;

    lock_code_fsm dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .slow_clk    (slow_clk),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .unlocked    (unlocked),
        .error       (error),
        .locked_out  (locked_out),
        .digit_count (digit_count),
        .fail_count  (fail_count),
        .state_o     (state_o)
    );

    always #20 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clk_in);
        key_valid = 1'b1;
        key_digit = d;
        @(negedge clk_in);
        key_valid = 1'b0;
        key_digit = 4'h0;
    endtask

    // Four keys, then one more cycle so the CHECK decision has landed
    task automatic enter4(input logic [15:0] c);
        press(c[15:12]);
        press(c[11:8]);
        press(c[7:4]);
        press(c[3:0]);
        @(negedge clk_in);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            slow_clk = 1'b1;
            repeat (4) @(negedge clk_in);
            slow_clk = 1'b0;
            repeat (4) @(negedge clk_in);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        slow_clk  = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'h0;
        repeat (3) @(negedge clk_in);
        chk("rst_state", 8'(state_o), 8'd0);
        chk("rst_flags", {5'd0, unlocked, error, locked_out}, 8'd0);
        chk("rst_counts", {2'd0, digit_count, fail_count}, 8'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);

        // Correct code
        press(4'd1); press(4'd2); press(4'd3);
        chk("ok_dcnt3", 8'(digit_count), 8'd3);
        chk("ok_state_entry", 8'(state_o), 8'd1);
        press(4'd4);
        chk("ok_state_check", 8'(state_o), 8'd2);
        chk("ok_unlock_not_yet", 8'(unlocked), 8'd0);
        @(negedge clk_in);
        chk("ok_unlocked", 8'(unlocked), 8'd1);
        chk("ok_fail0", 8'(fail_count), 8'd0);
        chk("ok_dcnt0", 8'(digit_count), 8'd0);
        ticks(14);
        chk("ok_open_14", 8'(unlocked), 8'd1);
        ticks(1);
        chk("ok_open_15", 8'(unlocked), 8'd0);
        chk("ok_idle", 8'(state_o), 8'd0);

        // Wrong code then right code
        enter4(16'h1235);
        chk("bad_error", 8'(error), 8'd1);
        chk("bad_fail1", 8'(fail_count), 8'd1);
        ticks(2);
        chk("bad_err_2", 8'(error), 8'd1);
        ticks(1);
        chk("bad_err_3", 8'(error), 8'd0);
        chk("bad_idle", 8'(state_o), 8'd0);
        enter4(16'h1234);
        chk("retry_open", 8'(unlocked), 8'd1);
        chk("retry_fail0", 8'(fail_count), 8'd0);
        ticks(15);
        chk("retry_idle", 8'(state_o), 8'd0);

        // Lockout after three failures
        enter4(16'h1235);
        chk("lk_fail1", 8'(fail_count), 8'd1);
        ticks(3);
        enter4(16'h1235);
        chk("lk_err2", 8'(error), 8'd1);
        chk("lk_fail2", 8'(fail_count), 8'd2);
        ticks(3);
        enter4(16'h1235);
        chk("lk_locked", 8'(locked_out), 8'd1);
        chk("lk_no_err", 8'(error), 8'd0);
        chk("lk_fail3", 8'(fail_count), 8'd3);
        press(4'd1); press(4'd2);
        chk("lk_keys_ignored", 8'(digit_count), 8'd0);
        chk("lk_state", 8'(state_o), 8'd5);
        ticks(59);
        chk("lk_59", 8'(locked_out), 8'd1);
        ticks(1);
        chk("lk_60_state", 8'(state_o), 8'd0);
        chk("lk_60_fail", 8'(fail_count), 8'd0);

        // Timeout discards partial entry
        press(4'd1); press(4'd2);
        ticks(9);
        chk("to_9_state", 8'(state_o), 8'd1);
        chk("to_9_dcnt", 8'(digit_count), 8'd2);
        ticks(1);
        chk("to_10_state", 8'(state_o), 8'd0);
        chk("to_10_dcnt", 8'(digit_count), 8'd0);
        chk("to_fail", 8'(fail_count), 8'd0);
        enter4(16'h3412);
        chk("to_fresh_err", 8'(error), 8'd1);
        chk("to_fresh_fail", 8'(fail_count), 8'd1);
        ticks(3);

        // Clear and ignored keys
        press(4'd1); press(4'd2); press(4'hC);
        chk("clr_dcnt", 8'(digit_count), 8'd0);
        chk("clr_state", 8'(state_o), 8'd0);
        press(4'hA);
        chk("ign_idle", 8'(state_o), 8'd0);
        press(4'd1); press(4'd2); press(4'hA);
        chk("ign_dcnt", 8'(digit_count), 8'd2);
        press(4'd3); press(4'd4);
        @(negedge clk_in);
        chk("clr_open", 8'(unlocked), 8'd1);
        chk("clr_fail0", 8'(fail_count), 8'd0);
        ticks(15);

        // Key coincident with the 10th tick restarts the timeout
        press(4'd1);
        ticks(9);
        @(negedge clk_in);
        slow_clk = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        key_valid = 1'b1;
        key_digit = 4'd2;
        @(negedge clk_in);
        key_valid = 1'b0;
        key_digit = 4'h0;
        chk("co_state", 8'(state_o), 8'd1);
        chk("co_dcnt", 8'(digit_count), 8'd2);
        repeat (2) @(negedge clk_in);
        slow_clk = 1'b0;
        repeat (4) @(negedge clk_in);
        ticks(9);
        chk("co_9_after", 8'(state_o), 8'd1);
        ticks(1);
        chk("co_10_after", 8'(state_o), 8'd0);

        // Asynchronous reset mid-OPEN
        enter4(16'h1234);
        chk("rs_open", 8'(unlocked), 8'd1);
        #5 rst_n = 1'b0;
        #1;
        chk("rs_open_unl", 8'(unlocked), 8'd0);
        chk("rs_open_state", 8'(state_o), 8'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        chk("rs_open_idle", 8'(state_o), 8'd0);

        // Asynchronous reset mid-ENTRY
        press(4'd1); press(4'd2);
        chk("rs_ent_dcnt", 8'(digit_count), 8'd2);
        #5 rst_n = 1'b0;
        #1;
        chk("rs_ent_dcnt0", 8'(digit_count), 8'd0);
        chk("rs_ent_state", 8'(state_o), 8'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);
        chk("rs_ent_idle", 8'(state_o), 8'd0);
        enter4(16'h1234);
        chk("rs_post_open", 8'(unlocked), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
